// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port. One access at a time, fixed-latency access
// window, one-cycle ready pulse back to the granted port.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  port_t                 last_grant_q, last_grant_d;
  port_t                 grant_q, grant_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic  d_req;
  logic  any_req;
  port_t pick;

  // Arbitration: a lone requester wins; on a tie the port not granted last time wins
  always_comb begin
    d_req   = d_read | d_write;
    any_req = if_req | d_req;
    pick    = (d_req && (!if_req || last_grant_q == PORT_IF)) ? PORT_D : PORT_IF;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RESP always returns to IDLE so a held request is not re-sampled there
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: grant latch, latency counter, per-port read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      last_grant_q <= PORT_D;
      grant_q      <= PORT_IF;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Datapath next values: latch the request on grant, count down, capture read data on the last access cycle
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = (pick == PORT_D) ? d_addr : if_addr;
          wdata_d      = d_wdata;
          // Store wins when both load and store are raised
          op_wr_d      = (pick == PORT_D) && d_write;
          cnt_d        = CNT_W'(MEM_LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!op_wr_q) begin
            if (grant_q == PORT_IF) if_rdata_d = mem_rdata;
            else                    d_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state so reset removes strobes and ready without a clock
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    mem_read  = (state_q == ACCESS) && !op_wr_q;
    mem_write = (state_q == ACCESS) && op_wr_q;
    if_ready  = (state_q == RESP) && (grant_q == PORT_IF);
    d_ready   = (state_q == RESP) && (grant_q == PORT_D);
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (MEM_LATENCY=2): cycle-by-cycle vector table
// plus hand-written reset-abort and held-request throughput sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        busy;

  mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model, combinational read
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] wd;
    logic        e_mrd;
    logic        e_mwr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic        e_ifrdy;
    logic        e_drdy;
    logic        e_busy;
    logic [31:0] e_ifrd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   row    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] wd,
                     input logic mrd, input logic mwr, input logic [31:0] maddr, input logic [31:0] mwd,
                     input logic ifrdy, input logic drdy, input logic bsy,
                     input logic [31:0] ifrd, input logic [31:0] drd);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
    v.e_mrd = mrd; v.e_mwr = mwr; v.e_maddr = maddr; v.e_mwd = mwd;
    v.e_ifrdy = ifrdy; v.e_drdy = drdy; v.e_busy = bsy; v.e_ifrd = ifrd; v.e_drd = drd;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W0 = 32'h11111111;
  localparam logic [31:0] W4 = 32'h22222222;
  localparam logic [31:0] SD = 32'h12345678;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  int rdy_cnt;
  int rd_cnt;
  int first_rdy;
  int consec;
  logic prev_rdy;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = DB;   // 0x100
    mem[0]  = W0;   // 0x000
    mem[16] = W4;   // 0x040

    //   rst ir ia      dr dw da      wd   | mrd mwr maddr   mwd ifr dr bsy ifrd drd
    // reset
    add(1, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h0,   '0, 0, 0, 0, '0, '0);
    // single fetch of 0x100
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    0, 0, 32'h0,   '0, 0, 0, 0, '0, '0);
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    1, 0, 32'h100, '0, 0, 0, 1, '0, '0);
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    1, 0, 32'h100, '0, 0, 0, 1, '0, '0);
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    0, 0, 32'h100, '0, 1, 0, 1, DB, '0);
    add(0, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h100, '0, 0, 0, 0, DB, '0);
    // reset clears read data and last_grant
    add(1, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h0,   '0, 0, 0, 0, '0, '0);
    // tie fetch 0x0 / load 0x40: fetch first
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h0,   '0, 0, 0, 0, '0, '0);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h0,   '0, 0, 0, 1, '0, '0);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h0,   '0, 0, 0, 1, '0, '0);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h0,   '0, 1, 0, 1, W0, '0);
    add(0, 0, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h0,   '0, 0, 0, 0, W0, '0);
    add(0, 0, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, '0);
    add(0, 0, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, '0);
    add(0, 0, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h40,  '0, 0, 1, 1, W0, W4);
    // repeated tie alternates: fetch, then load
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h40,  '0, 0, 0, 0, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h0,   '0, 0, 0, 1, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h0,   '0, 0, 0, 1, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h0,   '0, 1, 0, 1, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h0,   '0, 0, 0, 0, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, W4);
    add(0, 1, 32'h0,   1, 0, 32'h40, '0,    0, 0, 32'h40,  '0, 0, 1, 1, W0, W4);
    add(0, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h40,  '0, 0, 0, 0, W0, W4);
    // store 0x80, then load it back
    add(0, 0, 32'h0,   0, 1, 32'h80, SD,    0, 0, 32'h40,  '0, 0, 0, 0, W0, W4);
    add(0, 0, 32'h0,   0, 1, 32'h80, SD,    0, 1, 32'h80,  SD, 0, 0, 1, W0, W4);
    add(0, 0, 32'h0,   0, 1, 32'h80, SD,    0, 1, 32'h80,  SD, 0, 0, 1, W0, W4);
    add(0, 0, 32'h0,   0, 1, 32'h80, SD,    0, 0, 32'h80,  SD, 0, 1, 1, W0, W4);
    add(0, 0, 32'h0,   1, 0, 32'h80, '0,    0, 0, 32'h80,  SD, 0, 0, 0, W0, W4);
    add(0, 0, 32'h0,   1, 0, 32'h80, '0,    1, 0, 32'h80,  '0, 0, 0, 1, W0, W4);
    add(0, 0, 32'h0,   1, 0, 32'h80, '0,    1, 0, 32'h80,  '0, 0, 0, 1, W0, W4);
    add(0, 0, 32'h0,   1, 0, 32'h80, '0,    0, 0, 32'h80,  '0, 0, 1, 1, W0, SD);
    add(0, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h80,  '0, 0, 0, 0, W0, SD);
    // read+write together is a write; address change mid-access ignored
    add(0, 0, 32'h0,   1, 1, 32'hC0, A5,    0, 0, 32'h80,  '0, 0, 0, 0, W0, SD);
    add(0, 0, 32'h0,   1, 1, 32'h44, A5,    0, 1, 32'hC0,  A5, 0, 0, 1, W0, SD);
    add(0, 0, 32'h0,   1, 1, 32'h44, A5,    0, 1, 32'hC0,  A5, 0, 0, 1, W0, SD);
    add(0, 0, 32'h0,   1, 1, 32'h44, A5,    0, 0, 32'hC0,  A5, 0, 1, 1, W0, SD);
    add(0, 1, 32'h40,  0, 0, 32'h0,  '0,    0, 0, 32'hC0,  A5, 0, 0, 0, W0, SD);
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, SD);
    add(0, 1, 32'h100, 0, 0, 32'h0,  '0,    1, 0, 32'h40,  '0, 0, 0, 1, W0, SD);
    add(0, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h40,  '0, 1, 0, 1, W4, SD);
    add(0, 0, 32'h0,   0, 0, 32'h0,  '0,    0, 0, 32'h40,  '0, 0, 0, 0, W4, SD);

    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      row     = i;
      rst     = vecs[i].rst;
      if_req  = vecs[i].ir;
      if_addr = vecs[i].ia;
      d_read  = vecs[i].dr;
      d_write = vecs[i].dw;
      d_addr  = vecs[i].da;
      d_wdata = vecs[i].wd;
      @(negedge clk);
      chk("mem_read",  {31'b0, mem_read},  {31'b0, vecs[i].e_mrd});
      chk("mem_write", {31'b0, mem_write}, {31'b0, vecs[i].e_mwr});
      chk("mem_addr",  mem_addr,           vecs[i].e_maddr);
      chk("mem_wdata", mem_wdata,          vecs[i].e_mwd);
      chk("if_ready",  {31'b0, if_ready},  {31'b0, vecs[i].e_ifrdy});
      chk("d_ready",   {31'b0, d_ready},   {31'b0, vecs[i].e_drdy});
      chk("busy",      {31'b0, busy},      {31'b0, vecs[i].e_busy});
      chk("if_rdata",  if_rdata,           vecs[i].e_ifrd);
      chk("d_rdata",   d_rdata,            vecs[i].e_drd);
      @(posedge clk); #1;
    end

    // Memory contents written by the stores
    row = 1000;
    chk("mem_0x80", mem[32], SD);
    chk("mem_0xC0", mem[48], A5);

    // Reset in the first ACCESS cycle: strobes and busy drop at once
    row = 2000;
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk); #1;
    chk("abort_pre_mem_read", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
    chk("abort_busy",     {31'b0, busy},     32'd0);
    chk("abort_mem_addr", mem_addr,          32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abort_if_ready", {31'b0, if_ready}, 32'd0);
      @(posedge clk); #1;
    end

    // Held fetch after release: full latency, one ready per 4 cycles
    row = 3000;
    rst = 1'b0;
    rdy_cnt = 0; rd_cnt = 0; first_rdy = -1; consec = 0; prev_rdy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_read) rd_cnt++;
      if (if_ready) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = c;
        if (prev_rdy) consec++;
        chk("held_if_rdata", if_rdata, DB);
      end
      prev_rdy = if_ready;
      @(posedge clk); #1;
    end
    chk("held_first_ready", first_rdy, 32'd3);
    chk("held_ready_count", rdy_cnt,   32'd5);
    chk("held_read_cycles", rd_cnt,    32'd10);
    chk("held_consecutive", consec,    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data memory between the CPU's instruction-fetch port and its load/store port. Each port issues a level request. The arbiter grants one access at a time and drives the memory for a fixed multi-cycle access window. It then returns read data with a one-cycle ready pulse that the CPU uses to release its stall. It sits between `cpu` and `Memory` in the top level, replacing their direct connection.

## Interface
- `ADDR_WIDTH`, default 32: address width of both ports and the memory.
- `DATA_WIDTH`, default 32: data width.
- `MEM_LATENCY`, default 2: cycles the memory needs read/write asserted with address stable; must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request, level, held until `if_ready`.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_rdata` out DATA_WIDTH: fetched instruction; valid while `if_ready` is high.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `d_read` in 1: load request, level, held until `d_ready`.
- `d_write` in 1: store request, level, held until `d_ready`.
- `d_addr` in ADDR_WIDTH: data address.
- `d_wdata` in DATA_WIDTH: store data.
- `d_rdata` out DATA_WIDTH: load data; valid while `d_ready` is high.
- `d_ready` out 1: one-cycle completion pulse for load or store.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory read data, combinational from `mem_addr`.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, ACCESS and RESP.
- In IDLE, pending requests are `if_req` and `d_req = d_read | d_write`.
  - With no request pending, the FSM stays in IDLE.
  - With exactly one pending, that port is granted.
  - With both pending, the port not granted last time wins, using a `last_grant` register.
- On a grant, the FSM latches the address, write data, op (read or write) and granted port, then goes to ACCESS.
  - The latency counter loads `MEM_LATENCY-1`.
  - `last_grant` is updated to the granted port.
- If `d_read` and `d_write` are both high, the access is a write; `mem_read` stays low.
- In ACCESS:
  - `mem_addr`/`mem_wdata` come from the latched values. Input changes during ACCESS are ignored.
  - `mem_read` or `mem_write` is held high for exactly `MEM_LATENCY` cycles.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, `mem_rdata` is captured into the granted port's rdata register (reads only), and the FSM goes to RESP.
- In RESP:
  - The granted port's ready is high for one cycle; memory strobes are low.
  - Requests are not sampled in this cycle, so a held request is never re-granted.
  - The next state is IDLE.
- A store pulses `d_ready`; `d_rdata` keeps its previous value.
- The rdata registers hold their value until the next read completes on that port.
- Counter width is `$clog2(MEM_LATENCY)`, minimum 1 bit.

## Timing
- Request sampled in IDLE at edge k:
  - strobe high in cycles k+1 … k+MEM_LATENCY;
  - ready high in cycle k+MEM_LATENCY+1;
  - IDLE again in cycle k+MEM_LATENCY+2, where a new request may be granted.
- Peak throughput is one access per `MEM_LATENCY+2` cycles.
- A requester sees its ready and drops or changes its request in the next cycle.
- A request pending behind another is served immediately after, with no starvation under alternation.
- A request deasserted before grant is simply never served. A request deasserted during ACCESS does not abort the access.
- Reset values (immediate, asynchronous):
  - state IDLE, counter 0, `last_grant` = data, so the first tie goes to fetch;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` all 0;
  - `mem_read`, `mem_write`, `if_ready`, `d_ready`, `busy` all 0.
- Reset asserted mid-ACCESS or RESP abandons the access:
  - no ready pulse is issued;
  - strobes drop without waiting for a clock.
- After reset deasserts, the first rising edge samples requests in IDLE.

## Test plan
- Single fetch, `MEM_LATENCY=2`, memory word 0x100 = 0xDEADBEEF; `if_req`, `if_addr=0x100` held from edge 0 → `mem_read` high cycles 1–2 with `mem_addr=0x100`, `if_ready` high only in cycle 3 with `if_rdata=0xDEADBEEF`, `busy` low in cycle 4.
- Simultaneous `if_req` (0x0) and `d_read` (0x40) after reset → fetch served first (ready cycle 3), load granted at edge 4, `d_ready` in cycle 7; repeat the tie → order alternates.
- Store: `d_write`, `d_addr=0x80`, `d_wdata=0x12345678` → `mem_write` high exactly 2 cycles, `mem_read` low throughout, `d_ready` one cycle; a later load of 0x80 returns 0x12345678.
- `d_read`=`d_write`=1 → write performed, `mem_read` never asserted; `if_addr` changed mid-ACCESS → `mem_addr` stays at the latched value.
- Assert `rst` in the first ACCESS cycle → strobes and `busy` drop immediately, no ready pulse; after release, a held `if_req` is re-served with full latency.
- Requester holding `if_req` through RESP → exactly one `if_ready` per `MEM_LATENCY+2` cycles, never two consecutive ready cycles.
